// File: rtl/spike_rx_interface_pkg.sv
// Shared definitions for the spike receive interface: packet layout,
// CPU register offsets and CPU read FSM encodings.
package spike_rx_interface_pkg;

  localparam int unsigned PKT_W = 32;

  // Spike packet as carried on the router local port
  typedef struct packed {
    logic [3:0] dst_x;
    logic [3:0] dst_y;
    logic [3:0] src_x;
    logic [3:0] src_y;
    logic [7:0] src_neuron;
    logic [7:0] payload;
  } spike_pkt_t;

  // CPU-visible register byte offsets
  localparam logic [3:0] REG_STATUS   = 4'h0;
  localparam logic [3:0] REG_POP      = 4'h4;
  localparam logic [3:0] REG_PEEK     = 4'h8;
  localparam logic [3:0] REG_MISROUTE = 4'hC;

  // CPU read FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // STATUS word: sticky overflow in bit 31, occupancy in the low byte
  function automatic logic [PKT_W-1:0] status_word(input logic ovf, input logic [7:0] cnt);
    return {ovf, 23'b0, cnt};
  endfunction

endpackage

// File: rtl/spike_rx_interface_fifo.sv
// Synchronous packet FIFO: push/pop with full, empty, occupancy and head data.
// Pushes when full and pops when empty are ignored.
module spike_rx_interface_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and occupancy; power-of-two depth makes pointer wrap free
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/spike_rx_interface.sv
// Receive-side network interface of a mesh node. Filters packets from the
// router local port on destination, buffers local ones and serves them to the
// CPU through a busywait read port (STATUS / POP / PEEK / MISROUTE_COUNT).
// Optional feature macro: SPIKE_RX_IRQ_EN (registered occupancy interrupt).
module spike_rx_interface
  import spike_rx_interface_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned LOCAL_X       = 0,
  parameter int unsigned LOCAL_Y       = 0,
  parameter int unsigned IRQ_THRESHOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_in_valid,
  input  logic [DATA_WIDTH-1:0] pkt_in_data,
  output logic                  pkt_in_ready,
  input  logic                  mem_read,
  input  logic [3:0]            mem_address,
  output logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  mem_busywait,
  output logic                  spike_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Elaboration-time parameter sanity
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (IRQ_THRESHOLD > FIFO_DEPTH) begin : g_bad_thresh
    $error("IRQ_THRESHOLD exceeds FIFO_DEPTH");
  end

  spike_pkt_t            pkt_c;
  logic                  accept_c, is_local_c;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [PKT_W-1:0]      fifo_head;
  logic                  overflow_q;
  logic [PKT_W-1:0]      misroute_q;
  logic [1:0]            state_q, state_d;
  logic                  busy_c, rd_en_c, pop_c;
  logic [PKT_W-1:0]      rd_mux_c;
  logic [DATA_WIDTH-1:0] readdata_q;

  assign pkt_c        = spike_pkt_t'(pkt_in_data);
  assign pkt_in_ready = !fifo_full;
  assign accept_c     = pkt_in_valid && pkt_in_ready;
  assign is_local_c   = (pkt_c.dst_x == 4'(LOCAL_X)) && (pkt_c.dst_y == 4'(LOCAL_Y));

  spike_rx_interface_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept_c && is_local_c),
    .din_i   (pkt_c),
    .pop_i   (pop_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Sticky overflow flag and saturating misroute counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
      misroute_q <= '0;
    end else begin
      if (pkt_in_valid && fifo_full) overflow_q <= 1'b1;
      if (accept_c && !is_local_c && (misroute_q != '1)) misroute_q <= misroute_q + PKT_W'(1);
    end
  end

  // CPU read FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // CPU read FSM: one busywait cycle, capture on leaving IDLE, wait for mem_read to drop
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    rd_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read) begin
          busy_c  = 1'b1;
          rd_en_c = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_DONE;
      ST_DONE: if (!mem_read) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_busywait = busy_c;
  assign pop_c        = rd_en_c && (mem_address == REG_POP) && !fifo_empty;

  // Register read mux; empty FIFO and unaligned offsets read as zero
  always_comb begin
    rd_mux_c = '0;
    case (mem_address)
      REG_STATUS:   rd_mux_c = status_word(overflow_q, 8'(fifo_count));
      REG_POP,
      REG_PEEK:     rd_mux_c = fifo_empty ? '0 : fifo_head;
      REG_MISROUTE: rd_mux_c = misroute_q;
      default:      rd_mux_c = '0;
    endcase
  end

  // Read data register, loaded as the request is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         readdata_q <= '0;
    else if (rd_en_c) readdata_q <= DATA_WIDTH'(rd_mux_c);
  end

  assign mem_readdata = readdata_q;

`ifdef SPIKE_RX_IRQ_EN
  logic irq_q;

  // Occupancy interrupt, one cycle behind the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= (32'(fifo_count) >= IRQ_THRESHOLD);
  end

  assign spike_irq = irq_q;
`else
  assign spike_irq = 1'b0;
`endif

endmodule
